// File: rtl/pattern_match_ctrl.sv
// Run controller for the serial bit-pattern detector: programmable pattern and
// match goal, overlapping detection on a qualified bit stream, stops at goal.
module pattern_match_ctrl #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = 4'b1001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             din,
    input  logic             din_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [PAT_W-1:0]  HIST_ZERO = {PAT_W{1'b0}};
    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [PAT_W-1:0]   pattern_r, pattern_s;
    logic [CNT_W-1:0]   target_r, target_s;
    logic [PAT_W-1:0]   hist_r, hist_s;
    logic [FILL_W-1:0]  fill_r, fill_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic               match_r, match_s;

    logic [PAT_W-1:0]   hist_shift_s;
    logic [FILL_W-1:0]  fill_inc_s;
    logic [CNT_W-1:0]   count_inc_s;
    logic               hit_s;

    // A hit compares the post-shift history and fill, so it sees the bit arriving now.
    assign hist_shift_s = {hist_r[PAT_W-2:0], din};
    assign fill_inc_s   = (fill_r == FILL_FULL) ? fill_r : (fill_r + FILL_ONE);
    assign count_inc_s  = count_r + CNT_ONE;
    assign hit_s        = (hist_shift_s == pattern_r) && (fill_inc_s == FILL_FULL);

    assign cfg_ready   = (state_r == ST_IDLE);
    assign busy        = (state_r == ST_ARMED);
    assign done        = (state_r == ST_DONE);
    assign match       = match_r;
    assign match_count = count_r;

    // Next-state logic: abort overrides everything except rst, config beats start in IDLE.
    always_comb begin
        state_s   = state_r;
        pattern_s = pattern_r;
        target_s  = target_r;
        hist_s    = hist_r;
        fill_s    = fill_r;
        count_s   = count_r;
        match_s   = 1'b0;
        if (abort && (state_r != ST_IDLE)) begin
            state_s = ST_IDLE;
            hist_s  = HIST_ZERO;
            fill_s  = FILL_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        pattern_s = cfg_pattern;
                        target_s  = cfg_target;
                    end else if (start) begin
                        count_s = CNT_ZERO;
                        hist_s  = HIST_ZERO;
                        fill_s  = FILL_ZERO;
                        state_s = (target_r == CNT_ZERO) ? ST_DONE : ST_ARMED;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (din_valid) begin
                        hist_s = hist_shift_s;
                        fill_s = fill_inc_s;
                        if (hit_s) begin
                            match_s = 1'b1;
                            count_s = count_inc_s;
                            state_s = (count_inc_s == target_r) ? ST_DONE : ST_ARMED;
                        end else begin
                            state_s = ST_ARMED;
                        end
                    end else begin
                        state_s = ST_ARMED;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        count_s = CNT_ZERO;
                        hist_s  = HIST_ZERO;
                        fill_s  = FILL_ZERO;
                        state_s = (target_r == CNT_ZERO) ? ST_DONE : ST_ARMED;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    hist_s  = HIST_ZERO;
                    fill_s  = FILL_ZERO;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            pattern_r <= RST_PAT;
            target_r  <= CNT_ONE;
            hist_r    <= HIST_ZERO;
            fill_r    <= FILL_ZERO;
            count_r   <= CNT_ZERO;
            match_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            pattern_r <= pattern_s;
            target_r  <= target_s;
            hist_r    <= hist_s;
            fill_r    <= fill_s;
            count_r   <= count_s;
            match_r   <= match_s;
        end
    end

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Table-driven bench for pattern_match_ctrl; expected outputs of each vector go
// through a scoreboard queue and are compared one cycle after driving.
module tb_pattern_match_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_pattern = 4'd0;
    logic [7:0] cfg_target = 8'd0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       match;
    logic [7:0] match_count;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    pattern_match_ctrl #(.PAT_W(4), .CNT_W(8), .RST_PAT(4'b1001)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_target(cfg_target),
        .start(start), .abort(abort), .din(din), .din_valid(din_valid),
        .match(match), .match_count(match_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, cv;
        logic [3:0] pat;
        logic [7:0] tgt;
        logic       st, ab, d, dv;
        logic       em;
        logic [7:0] ec;
        logic       eb, ed, er;
    } vec_t;

    typedef struct {
        logic       em;
        logic [7:0] ec;
        logic       eb, ed, er;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic add(input logic r, cv, input logic [3:0] pat, input logic [7:0] tgt,
                       input logic st, ab, d, dv, em, input logic [7:0] ec,
                       input logic eb, ed, er);
        vec_t v;
        v.rst = r; v.cv = cv; v.pat = pat; v.tgt = tgt; v.st = st; v.ab = ab;
        v.d = d; v.dv = dv; v.em = em; v.ec = ec; v.eb = eb; v.ed = ed; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic bt(input logic d, dv, em, input logic [7:0] ec, input logic eb, ed, er);
        add(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, d, dv, em, ec, eb, ed, er);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic compare_all(input int idx, input exp_t e);
        vectors++;
        chk("match", idx, {7'd0, match}, {7'd0, e.em});
        chk("match_count", idx, match_count, e.ec);
        chk("busy", idx, {7'd0, busy}, {7'd0, e.eb});
        chk("done", idx, {7'd0, done}, {7'd0, e.ed});
        chk("cfg_ready", idx, {7'd0, cfg_ready}, {7'd0, e.er});
    endtask

    initial begin
        exp_t e;
        // Default pattern after reset
        add(1,0,4'd0,8'd0, 0,0,0,0, 0,8'd0,0,0,1);
        add(0,0,4'd0,8'd0, 1,0,0,0, 0,8'd0,1,0,0);
        bt(1,1, 0,8'd0,1,0,0); bt(0,1, 0,8'd0,1,0,0); bt(0,1, 0,8'd0,1,0,0);
        bt(1,1, 1,8'd1,0,1,0);
        bt(1,1, 0,8'd1,0,1,0);
        // Overlap: 1001 target 3
        add(0,0,4'd0,8'd0, 0,1,0,0, 0,8'd1,0,0,1);
        add(0,1,4'b1001,8'd3, 0,0,0,0, 0,8'd1,0,0,1);
        add(0,0,4'd0,8'd0, 1,0,0,0, 0,8'd0,1,0,0);
        bt(1,1, 0,8'd0,1,0,0); bt(0,1, 0,8'd0,1,0,0); bt(0,1, 0,8'd0,1,0,0);
        bt(1,1, 1,8'd1,1,0,0); bt(0,1, 0,8'd1,1,0,0); bt(0,1, 0,8'd1,1,0,0);
        bt(1,1, 1,8'd2,1,0,0); bt(0,1, 0,8'd2,1,0,0); bt(0,1, 0,8'd2,1,0,0);
        bt(1,1, 1,8'd3,0,1,0);
        // Fill guard with unqualified gaps carrying ones
        add(0,0,4'd0,8'd0, 0,1,0,0, 0,8'd3,0,0,1);
        add(0,1,4'b0000,8'd2, 0,0,0,0, 0,8'd3,0,0,1);
        add(0,0,4'd0,8'd0, 1,0,0,0, 0,8'd0,1,0,0);
        bt(0,1, 0,8'd0,1,0,0); bt(1,0, 0,8'd0,1,0,0); bt(0,1, 0,8'd0,1,0,0);
        bt(1,0, 0,8'd0,1,0,0); bt(0,1, 0,8'd0,1,0,0);
        bt(0,1, 1,8'd1,1,0,0); bt(1,0, 0,8'd1,1,0,0); bt(0,1, 1,8'd2,0,1,0);
        // Re-arm from DONE, contiguous zeros give back-to-back pulses
        add(0,0,4'd0,8'd0, 1,0,0,0, 0,8'd0,1,0,0);
        bt(0,1, 0,8'd0,1,0,0); bt(0,1, 0,8'd0,1,0,0); bt(0,1, 0,8'd0,1,0,0);
        bt(0,1, 1,8'd1,1,0,0); bt(0,1, 1,8'd2,0,1,0);
        // Config/start collision and offer held off while ARMED
        add(0,0,4'd0,8'd0, 0,1,0,0, 0,8'd2,0,0,1);
        add(0,1,4'b1001,8'd5, 1,0,0,0, 0,8'd2,0,0,1);
        add(0,0,4'd0,8'd0, 1,0,0,0, 0,8'd0,1,0,0);
        add(0,1,4'b0110,8'd1, 0,0,1,1, 0,8'd0,1,0,0);
        add(0,1,4'b0110,8'd1, 0,0,0,1, 0,8'd0,1,0,0);
        add(0,1,4'b0110,8'd1, 0,0,0,1, 0,8'd0,1,0,0);
        add(0,1,4'b0110,8'd1, 0,0,1,1, 1,8'd1,1,0,0);
        add(0,1,4'b0110,8'd1, 0,1,0,0, 0,8'd1,0,0,1);
        add(0,1,4'b0110,8'd1, 0,0,0,0, 0,8'd1,0,0,1);
        add(0,0,4'd0,8'd0, 1,0,0,0, 0,8'd0,1,0,0);
        bt(0,1, 0,8'd0,1,0,0); bt(1,1, 0,8'd0,1,0,0); bt(1,1, 0,8'd0,1,0,0);
        bt(0,1, 1,8'd1,0,1,0);
        // Target zero
        add(0,0,4'd0,8'd0, 0,1,0,0, 0,8'd1,0,0,1);
        add(0,1,4'b1111,8'd0, 0,0,0,0, 0,8'd1,0,0,1);
        add(0,0,4'd0,8'd0, 1,0,0,0, 0,8'd0,0,1,0);
        for (int i = 0; i < 5; i++) bt(1,1, 0,8'd0,0,1,0);
        // Abort suppresses a same-edge hit, history clears, rst mid-run
        add(0,0,4'd0,8'd0, 0,1,0,0, 0,8'd0,0,0,1);
        add(0,1,4'b1111,8'd9, 0,0,0,0, 0,8'd0,0,0,1);
        add(0,0,4'd0,8'd0, 1,0,0,0, 0,8'd0,1,0,0);
        for (int i = 0; i < 3; i++) bt(1,1, 0,8'd0,1,0,0);
        bt(1,1, 1,8'd1,1,0,0); bt(1,1, 1,8'd2,1,0,0);
        add(0,0,4'd0,8'd0, 0,1,1,1, 0,8'd2,0,0,1);
        add(0,0,4'd0,8'd0, 1,0,0,0, 0,8'd0,1,0,0);
        for (int i = 0; i < 3; i++) bt(1,1, 0,8'd0,1,0,0);
        bt(1,1, 1,8'd1,1,0,0);
        add(1,0,4'd0,8'd0, 0,0,1,1, 0,8'd0,0,0,1);
        add(0,0,4'd0,8'd0, 1,0,0,0, 0,8'd0,1,0,0);
        bt(1,1, 0,8'd0,1,0,0); bt(0,1, 0,8'd0,1,0,0); bt(0,1, 0,8'd0,1,0,0);
        bt(1,1, 1,8'd1,0,1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; cfg_valid = tbl[i].cv; cfg_pattern = tbl[i].pat;
            cfg_target = tbl[i].tgt; start = tbl[i].st; abort = tbl[i].ab;
            din = tbl[i].d; din_valid = tbl[i].dv;
            e.em = tbl[i].em; e.ec = tbl[i].ec; e.eb = tbl[i].eb;
            e.ed = tbl[i].ed; e.er = tbl[i].er;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            compare_all(i, e);
        end

        // Hand sequence: cfg_ready follows state, offer in DONE held until abort
        rst = 1'b0; start = 1'b0; din_valid = 1'b0; abort = 1'b0;
        cfg_valid = 1'b1; cfg_pattern = 4'b0011; cfg_target = 8'd1;
        #1;
        vectors++;
        chk("ready_in_done", 1000, {7'd0, cfg_ready}, 8'd0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        e.em = 1'b0; e.ec = 8'd1; e.eb = 1'b0; e.ed = 1'b0; e.er = 1'b1;
        compare_all(1001, e);
        @(posedge clk); #1;
        cfg_valid = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = (i >= 2) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        e.em = 1'b1; e.ec = 8'd1; e.eb = 1'b0; e.ed = 1'b1; e.er = 1'b0;
        compare_all(1002, e);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_match_ctrl.md
# pattern_match_ctrl

Run controller for the serial bit-pattern detector path. Holds a programmable PAT_W-bit target pattern and a match-count goal, loaded through a valid/ready config port. Arms on command, scans a qualified serial bit stream with overlapping detection, and pulses `match` per hit. Stops with `done` when the goal is reached. Sits between the software/config side and the serial data stream, replacing the hard-wired fixed-pattern detector.

## Interface
- `PAT_W`, 4: pattern length in bits (2..16).
- `CNT_W`, 8: width of match goal and match counter.
- `RST_PAT`, 4'b1001: pattern register reset value (PAT_W bits).

- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  config word offered.
- `cfg_ready`  out  1  config accepted this cycle when high with `cfg_valid`.
- `cfg_pattern`  in  PAT_W  pattern; bit PAT_W-1 is the oldest bit in time.
- `cfg_target`  in  CNT_W  number of matches ending the run.
- `start`  in  1  arm command (level sampled per cycle).
- `abort`  in  1  cancel run.
- `din`  in  1  serial data bit.
- `din_valid`  in  1  `din` qualified.
- `match`  out  1  one-cycle pulse per detected pattern.
- `match_count`  out  CNT_W  matches since last arm.
- `busy`  out  1  state == ARMED.
- `done`  out  1  state == DONE.

## Operation
- **States:**
  - IDLE: `cfg_ready`=1.
  - ARMED: scanning the stream.
  - DONE: goal reached, stream ignored.
- **Reset values:**
  - state IDLE.
  - pattern = RST_PAT; target = 1.
  - history = 0; fill = 0; `match_count` = 0.
  - `match` = 0; `busy` = 0; `done` = 0; `cfg_ready` = 1.
- **Config:** handshake completes only in IDLE. On completion, pattern and target registers load on that edge. `cfg_ready` is combinational from state and is 0 in ARMED/DONE. Offers made outside IDLE are held off, not dropped.
- **IDLE:**
  - `cfg_valid` and `start` in the same cycle: config is captured and `start` is ignored; state stays IDLE.
  - `start` alone with target != 0: go to ARMED; clear history, fill and `match_count`.
  - `start` alone with target == 0: go to DONE; clear `match_count`.
- **ARMED:**
  - Each cycle with `din_valid`=1 shifts `din` into history LSB: history = {history[PAT_W-2:0], din}.
  - fill increments, saturating at PAT_W.
  - A hit is when the post-shift history equals pattern and the post-shift fill equals PAT_W.
  - On a hit: `match` is registered high for the next cycle and `match_count` increments.
  - History is not cleared on a hit, so overlapping matches count.
  - If the incremented count equals target, go to DONE on the same edge.
  - Cycles with `din_valid`=0 change nothing.
- **DONE:**
  - `start` re-arms: go to ARMED and clear history, fill and `match_count`. The target == 0 rule applies as in IDLE.
  - `cfg_valid` is not accepted here.
- **abort:** highest priority after `rst`. From ARMED or DONE, go to IDLE next edge. `match_count` is retained for readout. History and fill are cleared. Any `match` pulse pending from the same edge is suppressed.
- **Counter arithmetic:** unsigned. `match_count` cannot exceed target, so no wrap.

## Timing
- **Hit latency:** bit sampled at edge N completes a pattern → `match`=1 and `match_count` updated during cycle N+1 (both registered at edge N). `match` deasserts at edge N+1 unless another hit occurs.
- **Final match:** on the hit that reaches target, `done`=1 in the same cycle as the final `match` pulse. `busy` drops in that cycle.
- **start → busy:** `start` sampled at edge N → `busy`=1 from cycle N+1. The first eligible data bit is the one sampled at edge N+1.
- **Throughput:** one bit per cycle; back-to-back hits produce consecutive `match` pulses (possible only for patterns with period 1, e.g. 1111).
- **rst mid-run:** all registers return to reset values at that edge, including the pattern. Any in-flight `match` is lost.

## Test plan
- **Default pattern:** reset, `start`, stream 1,0,0,1 with `din_valid`=1 → `match` pulse the cycle after the 4th bit; `match_count`=1; `done`=1 in the same cycle; `busy`=0.
- **Overlap:** config pattern 1001, target 3; stream 1,0,0,1,0,0,1,0,0,1 → `match` after bits 4, 7 and 10; `match_count`=3; `done` with the third pulse.
- **Fill guard and gaps:**
  - Config 0000, target 2; stream 0,0,0 → no match (fill < 4).
  - Two further 0s → matches after bits 4 and 5, `done`.
  - `din_valid`=0 cycles inserted between bits → identical result.
- **Config/start collision:**
  - `cfg_valid`+`start` together in IDLE → pattern loaded, state stays IDLE.
  - `cfg_valid` during ARMED → `cfg_ready`=0; the held offer is accepted the cycle after abort returns to IDLE.
- **Target zero:** target=0, `start` → `done`=1 next cycle, `match_count`=0, no `match` pulses for any stream.
- **Abort/reset mid-run:**
  - Pattern 1001, target 5; after 1 match, `abort` → IDLE, `match_count`=1 held, `busy`=0.
  - Re-`start` → count clears to 0.
  - `rst` while ARMED → all reset values, pattern = 1001.
